// File: rtl/ppm_encoder.sv
// ppm_encoder: turns the flight commands into a 4-channel PPM frame, snapshotting all inputs once per frame.
module ppm_encoder #(
  parameter int CLK_PER_US = 27,
  parameter int FRAME_US   = 20000,
  parameter int SEP_US     = 300,
  parameter int MIN_US     = 1000,
  parameter bit INVERT     = 1'b0
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [7:0] hover_i,
  input  logic [7:0] roll_i,
  input  logic [1:0] roll_direction_i,
  input  logic [7:0] pitch_i,
  input  logic       on_i,
  output logic       ppm_o,
  output logic       frame_start_o,
  output logic       busy_o
);
  localparam int PW = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
  localparam int UW = $clog2(FRAME_US + 1);
  typedef enum logic [1:0] {IDLE, SEP, MARK, SYNC} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] seg_q, seg_d, fus_q, fus_d, seg_len;
  logic [2:0] ch_q, ch_d;
  logic [7:0] roll_q, roll_d, pitch_q, pitch_d, thr_q, thr_d, cur_code, roll_snap;
  logic ppm_q, ppm_d, fs_q, fs_d, busy_q, busy_d;
  logic tick, seg_end, frame_end, snap, clr;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pre_q   <= '0;
      seg_q   <= '0;
      fus_q   <= '0;
      ch_q    <= '0;
      roll_q  <= '0;
      pitch_q <= '0;
      thr_q   <= '0;
      ppm_q   <= !INVERT;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      seg_q   <= seg_d;
      fus_q   <= fus_d;
      ch_q    <= ch_d;
      roll_q  <= roll_d;
      pitch_q <= pitch_d;
      thr_q   <= thr_d;
      ppm_q   <= ppm_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
    end
  end
  // Segments are whole microseconds; the prescaler restarts on every snapshot so they stay aligned.
  always_comb begin
    roll_snap = roll_direction_i == 2'd1 ? 8'd128 - {1'b0, roll_i[7:1]} :
                roll_direction_i == 2'd2 ? 8'd128 + {1'b0, roll_i[7:1]} : 8'd128;
    cur_code  = ch_q == 3'd0 ? roll_q : ch_q == 3'd1 ? pitch_q : ch_q == 3'd2 ? thr_q : 8'd128;
    tick      = pre_q == PW'(CLK_PER_US - 1);
    seg_len   = state_q == SEP ? UW'(SEP_US) : UW'(MIN_US - SEP_US) + (UW'(cur_code) << 2);
    seg_end   = tick && seg_q == seg_len - 1'b1;
    frame_end = tick && fus_q == UW'(FRAME_US - 1);
    snap      = enable_i && (state_q == IDLE || (state_q == SYNC && frame_end));
    clr       = snap || state_q == IDLE;
    state_d   = state_q;
    ch_d      = ch_q;
    case (state_q)
      IDLE: ;
      SEP:  if (seg_end) state_d = ch_q[2] ? SYNC : MARK;
      MARK: if (seg_end) begin
        state_d = SEP;
        ch_d    = ch_q + 3'd1;
      end
      SYNC: if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (snap) begin
      state_d = SEP;
      ch_d    = '0;
    end
    pre_d   = (clr || tick) ? '0 : pre_q + 1'b1;
    fus_d   = clr ? '0 : fus_q + UW'(tick);
    seg_d   = (clr || seg_end) ? '0 : seg_q + UW'(tick);
    roll_d  = snap ? roll_snap : roll_q;
    pitch_d = snap ? pitch_i : pitch_q;
    thr_d   = snap ? (on_i ? hover_i : 8'd0) : thr_q;
  end
  always_comb begin
    ppm_d  = INVERT ^ (state_d != SEP);
    busy_d = state_d != IDLE;
    fs_d   = snap;
  end
  assign ppm_o         = ppm_q;
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_ppm_encoder.sv
// tb_ppm_encoder: random command frames scored against a run-length model of the PPM waveform.
module tb_ppm_encoder;
  localparam int C = 2, F = 4600, S = 30, M = 100, FC = F * C;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, on;
  logic [7:0] hover, roll, pitch;
  logic [1:0] dir;
  logic ppm[2], fs[2], busy[2];
  int tests = 0, fails = 0, cyc = 0, t_fs = 0;
  bit discard = 1'b0;
  int exp_q[2][$];
  int rq[2][$];
  int cur_w[4];
  bit inf[2];
  bit cur[2];
  int len[2];
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ppm_encoder #(.CLK_PER_US(C), .FRAME_US(F), .SEP_US(S), .MIN_US(M), .INVERT(g == 1)) dut (
      .clock_i(clk), .reset_i(rst), .enable_i(en), .hover_i(hover), .roll_i(roll),
      .roll_direction_i(dir), .pitch_i(pitch), .on_i(on),
      .ppm_o(ppm[g]), .frame_start_o(fs[g]), .busy_o(busy[g]));
  end
  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask
  // Expected frame as alternating low/high run lengths in cycles, starting with a separator.
  function automatic void push_frame();
    int code[4];
    int sum = 0;
    code[0] = dir == 2'd1 ? 128 - int'(roll) / 2 : dir == 2'd2 ? 128 + int'(roll) / 2 : 128;
    code[1] = int'(pitch);
    code[2] = on ? int'(hover) : 0;
    code[3] = 128;
    for (int i = 0; i < 4; i++) begin
      cur_w[i] = M + 4 * code[i];
      sum += cur_w[i];
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[k].push_back(S * C);
        exp_q[k].push_back((cur_w[i] - S) * C);
      end
      exp_q[k].push_back(S * C);
      exp_q[k].push_back((F - sum - S) * C);
    end
  endfunction
  task automatic finish(input int k);
    int e[10];
    rq[k].push_back(len[k]);
    if (exp_q[k].size() < 10) check($sformatf("dut%0d unexpected frame", k), exp_q[k].size(), 10);
    else begin
      for (int i = 0; i < 10; i++) e[i] = exp_q[k].pop_front();
      if (!discard) begin
        check($sformatf("dut%0d run count", k), rq[k].size(), 10);
        if (rq[k].size() == 10)
          for (int i = 0; i < 10; i++) check($sformatf("dut%0d run%0d", k, i), rq[k][i], e[i]);
      end
    end
    rq[k].delete();
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit lvl;
      lvl = ppm[k] ^ (k == 1);
      if (fs[k]) begin
        if (inf[k]) finish(k);
        check($sformatf("dut%0d start level", k), lvl, 0);
        inf[k] = 1'b1;
        cur[k] = lvl;
        len[k] = 1;
      end else if (inf[k]) begin
        if (!busy[k]) begin
          finish(k);
          inf[k] = 1'b0;
        end else if (lvl == cur[k]) len[k]++;
        else begin
          rq[k].push_back(len[k]);
          cur[k] = lvl;
          len[k] = 1;
        end
      end
    end
  end
  task automatic set_in(input logic o, input logic [7:0] h, r, input logic [1:0] dr, input logic [7:0] p);
    on = o;
    hover = h;
    roll = r;
    dir = dr;
    pitch = p;
  endtask
  task automatic wait_fs(input string nm, input bit first);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs[0] && n < 3 * FC);
    check({nm, " seen"}, fs[0], 1);
    check({nm, " inv seen"}, fs[1], 1);
    if (first) check({nm, " delay"}, n, 1);
    else check({nm, " period"}, cyc - t_fs, FC);
    t_fs = cyc;
  endtask
  task automatic step(input int d, input logic o, input logic [7:0] h, r, input logic [1:0] dr,
                      input logic [7:0] p, input string nm);
    repeat (d) @(negedge clk);
    set_in(o, h, r, dr, p);
    push_frame();
    wait_fs(nm, 1'b0);
  endtask
  task automatic check_idle(input string nm);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d ppm", nm, k), ppm[k] ^ (k == 1), 1);
      check($sformatf("%s dut%0d busy", nm, k), busy[k], 0);
      check($sformatf("%s dut%0d frame_start", nm, k), fs[k], 0);
    end
  endtask
  initial begin
    int n, bad;
    rst = 1'b1;
    en = 1'b1;
    set_in(1'b1, 8'd0, 8'd0, 2'd0, 8'd255);
    repeat (5) @(negedge clk);
    check_idle("reset");
    push_frame();
    rst = 1'b0;
    wait_fs("reset release", 1'b1);
    step($urandom_range(1, 3000), 1'b0, 8'd200, 8'd100, 2'd1, 8'($urandom), "arm off left");
    step($urandom_range(1, 3000), 1'b1, 8'd200, 8'd255, 2'd2, 8'($urandom), "arm on right");
    step($urandom_range(1, 3000), 1'($urandom), 8'($urandom), 8'd255, 2'd3, 8'd0, "dir3 pitch0");
    step(S * C + 10, on, hover, roll, dir, 8'd255, "pitch change in ch0 mark");
    step($urandom_range(1, 3000), 1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), "random1");
    step($urandom_range(1, 3000), 1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), "random2");
    repeat ((cur_w[0] + S) * C + 5) @(negedge clk);
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[0] && n < 3 * FC);
    check("enable drop frame length", cyc - t_fs, FC);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (ppm[0] !== 1'b1 || ppm[1] !== 1'b0 || busy[0] || busy[1] || fs[0] || fs[1]) bad++;
    end
    check("idle hold", bad, 0);
    set_in(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom));
    push_frame();
    en = 1'b1;
    wait_fs("restart", 1'b1);
    repeat ((cur_w[0] + cur_w[1]) * C + 3) @(negedge clk);
    discard = 1'b1;
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    check_idle("reset in ch2 sep");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_idle("after reset");
    discard = 1'b0;
    check("dut0 leftover expectations", exp_q[0].size(), 0);
    check("dut1 leftover expectations", exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
